// File: rtl/seg_pkg.sv
// Shared seven-segment definitions: active-low pattern constants for the
// hex digits and blank, plus the segment bit ordering (bit0 = a .. bit6 = g).
// The hex-to-segment display block and the reader both draw on these.
package seg_pkg;

  localparam int SEG_W = 7;

  // Segment bit positions within a pattern
  localparam int SEG_A_BIT = 0;
  localparam int SEG_B_BIT = 1;
  localparam int SEG_C_BIT = 2;
  localparam int SEG_D_BIT = 3;
  localparam int SEG_E_BIT = 4;
  localparam int SEG_F_BIT = 5;
  localparam int SEG_G_BIT = 6;

  // Active-low patterns, written {g,f,e,d,c,b,a}
  localparam logic [SEG_W-1:0] SEG_0     = 7'b1000000;
  localparam logic [SEG_W-1:0] SEG_1     = 7'b1111001;
  localparam logic [SEG_W-1:0] SEG_2     = 7'b0100100;
  localparam logic [SEG_W-1:0] SEG_3     = 7'b0110000;
  localparam logic [SEG_W-1:0] SEG_4     = 7'b0011001;
  localparam logic [SEG_W-1:0] SEG_5     = 7'b0010010;
  localparam logic [SEG_W-1:0] SEG_6     = 7'b0000010;
  localparam logic [SEG_W-1:0] SEG_7     = 7'b1111000;
  localparam logic [SEG_W-1:0] SEG_8     = 7'b0000000;
  localparam logic [SEG_W-1:0] SEG_9     = 7'b0010000;
  localparam logic [SEG_W-1:0] SEG_A     = 7'b0001000;
  localparam logic [SEG_W-1:0] SEG_B     = 7'b0000011;
  localparam logic [SEG_W-1:0] SEG_C     = 7'b1000110;
  localparam logic [SEG_W-1:0] SEG_D     = 7'b0100001;
  localparam logic [SEG_W-1:0] SEG_E     = 7'b0000110;
  localparam logic [SEG_W-1:0] SEG_F     = 7'b0001110;
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;

  // True when every segment of the pattern is dark
  function automatic logic seg_is_blank(input logic [SEG_W-1:0] pat);
    return (pat == SEG_BLANK);
  endfunction

endpackage

// File: rtl/seven_segment_decoder.sv
// Combinational seven-segment pattern to hex nibble decoder.
// hit_o flags a recognised digit pattern; blank_o flags an all-dark pattern.
module seven_segment_decoder
  import seg_pkg::*;
(
  input  logic [SEG_W-1:0] seg_i,
  output logic [3:0]       value_o,
  output logic             hit_o,
  output logic             blank_o
);

  // Reverse lookup of the display table; anything else is a miss
  always_comb begin
    value_o = 4'h0;
    hit_o   = 1'b1;
    case (seg_i)
      SEG_0:   value_o = 4'h0;
      SEG_1:   value_o = 4'h1;
      SEG_2:   value_o = 4'h2;
      SEG_3:   value_o = 4'h3;
      SEG_4:   value_o = 4'h4;
      SEG_5:   value_o = 4'h5;
      SEG_6:   value_o = 4'h6;
      SEG_7:   value_o = 4'h7;
      SEG_8:   value_o = 4'h8;
      SEG_9:   value_o = 4'h9;
      SEG_A:   value_o = 4'hA;
      SEG_B:   value_o = 4'hB;
      SEG_C:   value_o = 4'hC;
      SEG_D:   value_o = 4'hD;
      SEG_E:   value_o = 4'hE;
      SEG_F:   value_o = 4'hF;
      default: hit_o   = 1'b0;
    endcase
    blank_o = seg_is_blank(seg_i);
  end

endmodule

// File: rtl/seven_segment_reader.sv
// Reads a multiplexed active-low seven-segment bus back into hex nibbles.
// A {SEG, DIG} sample must stay unchanged for STABLE_CYCLES samples before it
// is captured, once per stable window. Captures update the addressed digit,
// flag unknown patterns or multi-selects on ERR, and pulse FRAME once every
// digit has been refreshed.
// Optional build macro SEG_READER_SYNC_EN: inserts a 2-flop synchroniser
// (reset to all-ones) on SEG_IN and DIG_IN for asynchronous panels.
module seven_segment_reader
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 8
) (
  input  logic                    CLK,
  input  logic                    RST,
  input  logic [SEG_W-1:0]        SEG_IN,
  input  logic [NUM_DIGITS-1:0]   DIG_IN,
  output logic [4*NUM_DIGITS-1:0] OUT,
  output logic [NUM_DIGITS-1:0]   VALID,
  output logic                    ERR,
  output logic                    FRAME
);

  localparam int CNT_W = (STABLE_CYCLES > 1) ? $clog2(STABLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic [SEG_W-1:0]      seg_s;
  logic [NUM_DIGITS-1:0] dig_s;

`ifdef SEG_READER_SYNC_EN
  logic [SEG_W-1:0]      seg_meta_q, seg_sync_q;
  logic [NUM_DIGITS-1:0] dig_meta_q, dig_sync_q;

  // Two-flop synchroniser; idles at all-ones so reset looks like a dark bus
  always_ff @(posedge CLK) begin
    if (RST) begin
      seg_meta_q <= '1;
      seg_sync_q <= '1;
      dig_meta_q <= '1;
      dig_sync_q <= '1;
    end else begin
      seg_meta_q <= SEG_IN;
      seg_sync_q <= seg_meta_q;
      dig_meta_q <= DIG_IN;
      dig_sync_q <= dig_meta_q;
    end
  end

  assign seg_s = seg_sync_q;
  assign dig_s = dig_sync_q;
`else
  assign seg_s = SEG_IN;
  assign dig_s = DIG_IN;
`endif

  logic [SEG_W-1:0]      samp_seg_q;
  logic [NUM_DIGITS-1:0] samp_dig_q;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  cap_q, cap_d;
  logic                  diff;
  logic                  capture;

  // A new sample restarts the window; the window wins over a same-cycle capture
  always_comb begin
    diff    = (seg_s != samp_seg_q) || (dig_s != samp_dig_q);
    capture = (cnt_q == CNT_MAX) && !cap_q;
    cnt_d   = cnt_q;
    cap_d   = cap_q;
    if (diff) begin
      cnt_d = '0;
      cap_d = 1'b0;
    end else begin
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + CNT_W'(1);
      if (capture)          cap_d = 1'b1;
    end
  end

  // Sample register and stability tracking
  always_ff @(posedge CLK) begin
    if (RST) begin
      samp_seg_q <= '1;
      samp_dig_q <= '1;
      cnt_q      <= '0;
      cap_q      <= 1'b0;
    end else begin
      samp_seg_q <= seg_s;
      samp_dig_q <= dig_s;
      cnt_q      <= cnt_d;
      cap_q      <= cap_d;
    end
  end

  logic [3:0] dec_value;
  logic       dec_hit;
  logic       dec_blank;

  seven_segment_decoder u_dec (
    .seg_i   (samp_seg_q),
    .value_o (dec_value),
    .hit_o   (dec_hit),
    .blank_o (dec_blank)
  );

  // Select decoding: DIG is active-low, so selected digits are the zeros
  logic [NUM_DIGITS-1:0] sel;
  logic                  one_sel;
  logic                  multi_sel;

  always_comb begin
    sel       = ~samp_dig_q;
    one_sel   = (sel != '0) && ((sel & (sel - NUM_DIGITS'(1))) == '0);
    multi_sel = (sel != '0) && !one_sel;
  end

  logic [4*NUM_DIGITS-1:0] out_q, out_d;
  logic [NUM_DIGITS-1:0]   valid_q, valid_d;
  logic [NUM_DIGITS-1:0]   seen_q, seen_d;
  logic                    err_q, err_d;
  logic                    frame_q, frame_d;

  // Capture action on the addressed digit, error and frame bookkeeping
  always_comb begin
    out_d   = out_q;
    valid_d = valid_q;
    seen_d  = seen_q;
    err_d   = 1'b0;
    frame_d = 1'b0;
    if (capture) begin
      if (one_sel) begin
        for (int i = 0; i < NUM_DIGITS; i++) begin
          if (sel[i]) begin
            if (dec_hit) begin
              out_d[4*i +: 4] = dec_value;
              valid_d[i]      = 1'b1;
            end else begin
              valid_d[i]      = 1'b0;
            end
            seen_d[i] = 1'b1;
          end
        end
        err_d = !dec_hit && !dec_blank;
        // The completing capture closes the frame and does not carry over
        if (&seen_d) begin
          frame_d = 1'b1;
          seen_d  = '0;
        end
      end else if (multi_sel) begin
        err_d = 1'b1;
      end
    end
  end

  // Per-digit output registers and seen mask
  always_ff @(posedge CLK) begin
    if (RST) begin
      out_q   <= '0;
      valid_q <= '0;
      seen_q  <= '0;
      err_q   <= 1'b0;
      frame_q <= 1'b0;
    end else begin
      out_q   <= out_d;
      valid_q <= valid_d;
      seen_q  <= seen_d;
      err_q   <= err_d;
      frame_q <= frame_d;
    end
  end

  assign OUT   = out_q;
  assign VALID = valid_q;
  assign ERR   = err_q;
  assign FRAME = frame_q;

endmodule

// File: tb/tb_seven_segment_reader.sv
// Self-checking bench for seven_segment_reader (4 digits, 4-cycle window).
// Each held pattern long enough to be captured pushes the expected outcome,
// tagged with the edge at which it must appear; a negedge monitor pops and
// compares, and checks that nothing changes in between.
module tb_seven_segment_reader;

  localparam int ND = 4;
  localparam int S  = 4;

  logic            CLK = 1'b0;
  logic            RST = 1'b1;
  logic [6:0]      SEG_IN = 7'h7F;
  logic [ND-1:0]   DIG_IN = '1;
  logic [4*ND-1:0] OUT;
  logic [ND-1:0]   VALID;
  logic            ERR;
  logic            FRAME;

  seven_segment_reader #(.NUM_DIGITS(ND), .STABLE_CYCLES(S)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .SEG_IN(SEG_IN),
    .DIG_IN(DIG_IN),
    .OUT   (OUT),
    .VALID (VALID),
    .ERR   (ERR),
    .FRAME (FRAME)
  );

  always #5 CLK = ~CLK;

  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  typedef struct {
    int              cyc;
    logic [4*ND-1:0] out;
    logic [ND-1:0]   valid;
    logic            err;
    logic            frame;
  } exp_t;

  exp_t q[$];

  // Reference state of the display as the bench expects it
  logic [4*ND-1:0] m_out   = '0;
  logic [ND-1:0]   m_valid = '0;
  logic [ND-1:0]   m_seen  = '0;
  logic [4*ND-1:0] vis_out   = '0;
  logic [ND-1:0]   vis_valid = '0;
  bit              mon_en = 1'b0;

  logic [6:0] tbl [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                           7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                           7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                           7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  task automatic model_capture(input logic [ND-1:0] dig, input logic [6:0] seg, input int at);
    exp_t e;
    int   nlow, idx, val;
    nlow = 0; idx = 0; val = -1;
    for (int i = 0; i < ND; i++) if (!dig[i]) begin nlow++; idx = i; end
    for (int v = 0; v < 16; v++) if (tbl[v] == seg) val = v;
    e.cyc = at; e.err = 1'b0; e.frame = 1'b0;
    if (nlow == 0) return;
    if (nlow > 1) begin
      e.err = 1'b1;
    end else begin
      if (val >= 0) begin
        m_out[4*idx +: 4] = 4'(val);
        m_valid[idx] = 1'b1;
      end else begin
        m_valid[idx] = 1'b0;
        e.err = (seg != 7'h7F);
      end
      m_seen[idx] = 1'b1;
      if (m_seen == '1) begin
        e.frame = 1'b1;
        m_seen  = '0;
      end
    end
    e.out = m_out; e.valid = m_valid;
    q.push_back(e);
  endtask

  // Drive a pattern right after an edge and hold it for n edges
  task automatic hold(input logic [ND-1:0] dig, input logic [6:0] seg, input int n);
    DIG_IN = dig;
    SEG_IN = seg;
    if (n >= S) model_capture(dig, seg, cyc + 1 + S);
    repeat (n) begin @(posedge CLK); #1; end
  endtask

  // Scoreboard monitor, sampling on the falling edge
  always @(negedge CLK) begin
    if (mon_en) begin
      if (q.size() > 0 && q[0].cyc == cyc) begin
        exp_t e;
        e = q.pop_front();
        vis_out   = e.out;
        vis_valid = e.valid;
        chk("cap_err", ERR, e.err);
        chk("cap_frame", FRAME, e.frame);
      end else begin
        chk("idle_err", ERR, 1'b0);
        chk("idle_frame", FRAME, 1'b0);
      end
      chk("out", OUT, vis_out);
      chk("valid", VALID, vis_valid);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    n_fail++;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    // Reset
    RST = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b0;
    chk("rst_out", OUT, 16'h0);
    chk("rst_valid", VALID, 4'h0);
    chk("rst_err", ERR, 1'b0);
    chk("rst_frame", FRAME, 1'b0);
    mon_en = 1'b1;

    // Single held digit, captured once
    hold(4'b1110, 7'b0110000, 24);
    chk("hold_out", OUT, 16'h0003);
    chk("hold_valid", VALID, 4'b0001);

    // Scan of all four digits
    hold(4'b1110, 7'b0100100, 4);
    hold(4'b1111, 7'h7F, 1);
    hold(4'b1101, 7'b0001000, 4);
    hold(4'b1111, 7'h7F, 1);
    hold(4'b1011, 7'b0001110, 4);
    hold(4'b1111, 7'h7F, 1);
    hold(4'b0111, 7'b1111000, 4);
    hold(4'b1111, 7'h7F, 2);
    chk("scan_out", OUT, 16'h7FA2);
    chk("scan_valid", VALID, 4'b1111);

    // Invalid pattern, multi-select, blank digit
    hold(4'b1101, 7'b1010101, 4);
    hold(4'b0011, 7'b0000000, 4);
    hold(4'b1011, 7'h7F, 4);
    hold(4'b1111, 7'h7F, 2);
    chk("bad_valid", VALID, 4'b1001);
    chk("bad_nibble", OUT[7:4], 4'hA);

    // Glitching digit never settles
    for (int i = 0; i < 5; i++) begin
      hold(4'b1110, 7'b0000000, 2);
      hold(4'b1110, 7'b1111001, 2);
    end
    hold(4'b1111, 7'h7F, 3);

    // Reset in the middle of a window
    hold(4'b1110, 7'b0000000, 2);
    mon_en = 1'b0;
    RST = 1'b1;
    @(posedge CLK);
    #1;
    RST = 1'b0;
    chk("mid_rst_out", OUT, 16'h0);
    chk("mid_rst_valid", VALID, 4'h0);
    chk("mid_rst_err", ERR, 1'b0);
    chk("mid_rst_frame", FRAME, 1'b0);
    q.delete();
    m_out = '0; m_valid = '0; m_seen = '0;
    vis_out = '0; vis_valid = '0;
    mon_en = 1'b1;
    hold(4'b1110, 7'b0000000, 6);
    hold(4'b1111, 7'h7F, 2);
    chk("post_rst_out", OUT, 16'h0008);
    chk("post_rst_valid", VALID, 4'b0001);

    chk("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
